// File: rtl/clkgen_pkg.sv
// Shared types and helpers for the multi-channel clock/strobe generator.
// Holds the request record, the lock FSM states and the clamp rule that is
// applied to every accepted reconfiguration request.
package clkgen_pkg;

    // Width of the channel index on the configuration port.
    localparam int CH_IDX_W  = 4;

    // Widest counter the shared record can carry. CNT_W of the top must not
    // exceed this value. Narrower values are zero-extended into the record.
    localparam int CNT_W_MAX = 16;

    typedef struct packed {
        logic [CNT_W_MAX-1:0] div;
        logic [CNT_W_MAX-1:0] high;
        logic [CNT_W_MAX-1:0] phase;
    } cfg_t;

    typedef enum logic [1:0] {
        UNLOCKED = 2'd0,
        PENDING  = 2'd1,
        SETTLE   = 2'd2,
        LOCKED   = 2'd3
    } lock_state_t;

    // A divide ratio below 2 cannot produce a period, so it becomes 2.
    // The phase must land inside the period, so it is capped at div-1.
    // high needs no rewrite: 0 already gives constant low, and any value
    // >= div already gives constant high through the cnt < high compare.
    function automatic cfg_t clamp_cfg(input cfg_t req);
        cfg_t res;
        res = req;
        if (req.div < CNT_W_MAX'(2)) begin
            res.div = CNT_W_MAX'(2);
        end
        if (res.phase >= res.div) begin
            res.phase = res.div - CNT_W_MAX'(1);
        end
        return res;
    endfunction

endpackage

// File: rtl/clkgen_multi_if.sv
// Reconfiguration port of clkgen_multi: valid/ready request with channel
// index and the new divide/high/phase values, plus the reject pulse.
interface clkgen_multi_if #(
    parameter int CNT_W = 8
);
    import clkgen_pkg::*;

    logic                cfg_valid;
    logic                cfg_ready;
    logic [CH_IDX_W-1:0] cfg_ch;
    logic [CNT_W-1:0]    cfg_div;
    logic [CNT_W-1:0]    cfg_high;
    logic [CNT_W-1:0]    cfg_phase;
    logic                cfg_err;

    // Requester side.
    modport master (
        output cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
        input  cfg_ready, cfg_err
    );

    // Generator side.
    modport slave (
        input  cfg_valid, cfg_ch, cfg_div, cfg_high, cfg_phase,
        output cfg_ready, cfg_err
    );

endinterface

// File: rtl/clkgen_chan.sv
// One output channel: period counter, active configuration, and the
// boundary-aligned apply of a pending request so no runt period appears.
module clkgen_chan #(
    parameter int CNT_W    = 8,
    parameter int DEF_DIV  = 5,
    parameter int DEF_HIGH = 4
) (
    input  logic             refclk,
    input  logic             rst,
    input  logic             i_apply_req,
    input  logic [CNT_W-1:0] i_div,
    input  logic [CNT_W-1:0] i_high,
    input  logic [CNT_W-1:0] i_phase,
    input  logic             i_align,
    output logic             o_applied,
    output logic             o_outclk,
    output logic             o_tick
);

    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] r_div;
    logic [CNT_W-1:0] r_high;
    logic [CNT_W-1:0] r_phase;
    logic             r_outclk;
    logic             r_tick;
    logic             w_last;

    assign w_last = (r_cnt == r_div - CNT_W'(1));

    // A request lands on the last count of the current period. An align pulse
    // pushes it through at once so the realigned channels start on the new values.
    assign o_applied = i_apply_req && (w_last || i_align);

    // Period counter and the configuration it runs against.
    always_ff @(posedge refclk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of statement or block order.
        if (rst) begin
            r_cnt   <= '0;
            r_div   <= CNT_W'(DEF_DIV);
            r_high  <= CNT_W'(DEF_HIGH);
            r_phase <= '0;
        end else if (o_applied) begin
            r_div   <= i_div;
            r_high  <= i_high;
            r_phase <= i_phase;
            r_cnt   <= i_phase;
        end else if (i_align) begin
            r_cnt   <= r_phase;
        end else if (w_last) begin
            r_cnt   <= '0;
        end else begin
            r_cnt   <= r_cnt + CNT_W'(1);
        end
    end

    // Outputs are registered one cycle behind the counter.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_outclk <= 1'b0;
            r_tick   <= 1'b0;
        end else begin
            r_outclk <= (r_cnt < r_high);
            r_tick   <= (r_cnt == '0);
        end
    end

    assign o_outclk = r_outclk;
    assign o_tick   = r_tick;

endmodule

// File: rtl/clkgen_multi.sv
// Multi-channel programmable clock/strobe generator on the 50 MHz refclk.
// Holds the single pending reconfiguration slot, the lock FSM and the reject
// pulse; each output is produced by one clkgen_chan instance.
// Optional feature: define CLKGEN_ALIGN_EN to add the 'align' input, which
// restarts every channel at its last-applied phase.
module clkgen_multi
    import clkgen_pkg::*;
#(
    parameter int NUM_CH      = 4,
    parameter int CNT_W       = 8,
    parameter int DEF_DIV     = 5,
    parameter int DEF_HIGH    = 4,
    parameter int LOCK_CYCLES = 16
) (
    input  logic              refclk,
    input  logic              rst,
`ifdef CLKGEN_ALIGN_EN
    input  logic              align,
`endif
    clkgen_multi_if.slave     cfg,
    output logic [NUM_CH-1:0] outclk,
    output logic [NUM_CH-1:0] tick,
    output logic              locked
);

    localparam int LCNT_W = $clog2(LOCK_CYCLES) + 1;

    logic                r_pend_vld;
    logic [CH_IDX_W-1:0] r_pend_ch;
    logic [CNT_W-1:0]    r_pend_div;
    logic [CNT_W-1:0]    r_pend_high;
    logic [CNT_W-1:0]    r_pend_phase;
    logic                r_err;
    lock_state_t         r_state;
    lock_state_t         w_state_nxt;
    logic [LCNT_W-1:0]   r_lcnt;
    logic [LCNT_W-1:0]   w_lcnt_nxt;
    logic                w_accept;
    logic                w_ch_ok;
    logic                w_align;
    logic                w_applied;
    logic [NUM_CH-1:0]   w_apply_req;
    logic [NUM_CH-1:0]   w_applied_vec;
    cfg_t                w_req;
    cfg_t                w_clamp;
    logic                w_unused_clamp;

`ifdef CLKGEN_ALIGN_EN
    assign w_align = align;
`else
    assign w_align = 1'b0;
`endif

    // The slot is free exactly when nothing is pending.
    assign cfg.cfg_ready = ~r_pend_vld;
    assign cfg.cfg_err   = r_err;
    assign w_accept      = cfg.cfg_valid & ~r_pend_vld;
    assign w_ch_ok       = (32'(cfg.cfg_ch) < NUM_CH);

    assign w_req = '{div:   CNT_W_MAX'(cfg.cfg_div),
                     high:  CNT_W_MAX'(cfg.cfg_high),
                     phase: CNT_W_MAX'(cfg.cfg_phase)};
    assign w_clamp = clamp_cfg(w_req);
    // Bits above CNT_W are zero by construction and intentionally dropped.
    assign w_unused_clamp = ^w_clamp;

    // Pending slot: filled on a valid accept, emptied when its channel applies.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_pend_vld   <= 1'b0;
            r_pend_ch    <= '0;
            r_pend_div   <= '0;
            r_pend_high  <= '0;
            r_pend_phase <= '0;
        end else if (w_accept && w_ch_ok) begin
            r_pend_vld   <= 1'b1;
            r_pend_ch    <= cfg.cfg_ch;
            r_pend_div   <= w_clamp.div[CNT_W-1:0];
            r_pend_high  <= w_clamp.high[CNT_W-1:0];
            r_pend_phase <= w_clamp.phase[CNT_W-1:0];
        end else if (w_applied) begin
            r_pend_vld   <= 1'b0;
        end
    end

    // Reject pulse for an out-of-range channel index; the request is consumed.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_accept && !w_ch_ok;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        assign w_apply_req[i] = r_pend_vld && (r_pend_ch == CH_IDX_W'(i));

        clkgen_chan #(
            .CNT_W    (CNT_W),
            .DEF_DIV  (DEF_DIV),
            .DEF_HIGH (DEF_HIGH)
        ) u_chan (
            .refclk      (refclk),
            .rst         (rst),
            .i_apply_req (w_apply_req[i]),
            .i_div       (r_pend_div),
            .i_high      (r_pend_high),
            .i_phase     (r_pend_phase),
            .i_align     (w_align),
            .o_applied   (w_applied_vec[i]),
            .o_outclk    (outclk[i]),
            .o_tick      (tick[i])
        );
    end

    assign w_applied = |w_applied_vec;

    // Lock FSM next state: a new accept wins, then any restart into SETTLE,
    // then the settle count toward LOCKED.
    always_comb begin
        // NOTE: every output of this block gets a default first, so no path
        // leaves a value unassigned and no latch is inferred.
        w_state_nxt = r_state;
        w_lcnt_nxt  = r_lcnt;
        if (w_accept && w_ch_ok) begin
            w_state_nxt = PENDING;
        end else if (r_state == UNLOCKED || w_applied || w_align) begin
            w_state_nxt = SETTLE;
            w_lcnt_nxt  = '0;
        end else if (r_state == SETTLE) begin
            w_lcnt_nxt = r_lcnt + LCNT_W'(1);
            if (w_lcnt_nxt >= LCNT_W'(LOCK_CYCLES - 1)) begin
                w_state_nxt = LOCKED;
            end
        end
    end

    // Lock FSM state and settle counter.
    always_ff @(posedge refclk) begin
        if (rst) begin
            r_state <= UNLOCKED;
            r_lcnt  <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_lcnt  <= w_lcnt_nxt;
        end
    end

    assign locked = (r_state == LOCKED);

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi: boot defaults, boundary reconfiguration,
// clamping, reject pulse, reset while pending, and (with CLKGEN_ALIGN_EN) align.
`timescale 1ns/1ps
module tb_clkgen_multi;

    localparam int NUM_CH = 4;
    localparam int CNT_W  = 8;

    logic              refclk = 1'b0;
    logic              rst    = 1'b1;
    logic [NUM_CH-1:0] outclk;
    logic [NUM_CH-1:0] tick;
    logic              locked;
`ifdef CLKGEN_ALIGN_EN
    logic              align  = 1'b0;
`endif

    int n_tests = 0;
    int n_fail  = 0;

    clkgen_multi_if #(.CNT_W(CNT_W)) cfg_bus ();

    clkgen_multi #(
        .NUM_CH      (NUM_CH),
        .CNT_W       (CNT_W),
        .DEF_DIV     (5),
        .DEF_HIGH    (4),
        .LOCK_CYCLES (16)
    ) dut (
        .refclk (refclk),
        .rst    (rst),
`ifdef CLKGEN_ALIGN_EN
        .align  (align),
`endif
        .cfg    (cfg_bus),
        .outclk (outclk),
        .tick   (tick),
        .locked (locked)
    );

    // 50 MHz reference.
    always #10 refclk = ~refclk;

    initial begin
        #1000000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge refclk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Present one request for a single cycle; returns just after the accept edge.
    task automatic send(input logic [3:0] ch, input logic [7:0] div,
                        input logic [7:0] high, input logic [7:0] phase);
        cfg_bus.cfg_valid = 1'b1;
        cfg_bus.cfg_ch    = ch;
        cfg_bus.cfg_div   = div;
        cfg_bus.cfg_high  = high;
        cfg_bus.cfg_phase = phase;
        step();
        cfg_bus.cfg_valid = 1'b0;
    endtask

    task automatic wait_ready(input string tag);
        int w = 0;
        while (cfg_bus.cfg_ready !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        check(tag, cfg_bus.cfg_ready, 1);
    endtask

    // Defaults on all channels after reset release: period 5, high 4, tick on
    // cycle 1, locked from cycle 16.
    task automatic check_default_run(input string tag, input int n);
        for (int k = 1; k <= n; k++) begin
            step();
            check({tag, " outclk"}, outclk, ((k - 1) % 5 < 4) ? 4'hF : 4'h0);
            check({tag, " tick"},   tick,   ((k - 1) % 5 == 0) ? 4'hF : 4'h0);
            check({tag, " locked"}, locked, (k >= 16));
        end
    endtask

    initial begin
        int w;
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_ch    = '0;
        cfg_bus.cfg_div   = '0;
        cfg_bus.cfg_high  = '0;
        cfg_bus.cfg_phase = '0;

        // Reset state.
        rst = 1'b1;
        repeat (3) step();
        check("rst outclk", outclk, 0);
        check("rst tick",   tick,   0);
        check("rst locked", locked, 0);
        check("rst err",    cfg_bus.cfg_err,   0);
        check("rst ready",  cfg_bus.cfg_ready, 1);

        rst = 1'b0;
        check_default_run("boot", 16);

        // ch1 -> div 10 high 5, presented while cnt1 = 2, accepted at edge 18.
        step();
        check("ch1 ready idle", cfg_bus.cfg_ready, 1);
        send(4'd1, 8'd10, 8'd5, 8'd0);
        check("ch1 ready drop",  cfg_bus.cfg_ready, 0);
        check("ch1 locked drop", locked, 0);
        step();
        check("ch1 pending", cfg_bus.cfg_ready, 0);
        step();
        check("ch1 ready back",   cfg_bus.cfg_ready, 1);
        check("ch1 old last low", outclk[1], 0);
        for (int j = 1; j <= 15; j++) begin
            step();
            check("ch1 outclk", outclk[1], ((j - 1) % 10 < 5));
            check("ch1 tick",   tick[1],   ((j - 1) % 10 == 0));
            check("ch0 steady", outclk[0], ((19 + j) % 5 < 4));
            check("ch1 relock", locked,    (j == 15));
        end

        // ch2 -> div 1 high 0: clamped to div 2, constant low, tick every 2.
        send(4'd2, 8'd1, 8'd0, 8'd0);
        check("ch2 ready drop", cfg_bus.cfg_ready, 0);
        wait_ready("ch2 apply");
        for (int j = 1; j <= 6; j++) begin
            step();
            check("ch2 outclk", outclk[2], 0);
            check("ch2 tick",   tick[2],   (j % 2 == 1));
        end

        // ch3 -> div 8 high 9: constant high, tick every 8.
        send(4'd3, 8'd8, 8'd9, 8'd0);
        wait_ready("ch3 apply");
        for (int j = 1; j <= 9; j++) begin
            step();
            check("ch3 outclk", outclk[3], 1);
            check("ch3 tick",   tick[3],   ((j - 1) % 8 == 0));
        end

        w = 0;
        while (locked !== 1'b1 && w < 40) begin
            step();
            w++;
        end
        check("relock before reject", locked, 1);

        // Out-of-range channel: consumed, error pulse, nothing else moves.
        send(4'd7, 8'd3, 8'd1, 8'd0);
        check("rej err",    cfg_bus.cfg_err,   1);
        check("rej ready",  cfg_bus.cfg_ready, 1);
        check("rej locked", locked, 1);
        step();
        check("rej err one", cfg_bus.cfg_err, 0);
        check("rej locked2", locked, 1);
        check("rej ch3",     outclk[3], 1);
        check("rej ch2",     outclk[2], 0);

        // Reset with a request pending: request discarded, defaults back.
        send(4'd1, 8'd20, 8'd3, 8'd0);
        check("pend ready", cfg_bus.cfg_ready, 0);
        rst = 1'b1;
        step();
        check("mid-rst ready",  cfg_bus.cfg_ready, 1);
        check("mid-rst outclk", outclk, 0);
        check("mid-rst tick",   tick,   0);
        check("mid-rst locked", locked, 0);
        check("mid-rst err",    cfg_bus.cfg_err, 0);
        rst = 1'b0;
        check_default_run("post-rst", 16);

`ifdef CLKGEN_ALIGN_EN
        // ch1 phase 2 at div 5, then align: ch1 leads ch0 by 2 cycles.
        send(4'd1, 8'd5, 8'd4, 8'd2);
        wait_ready("align cfg apply");
        align = 1'b1;
        step();
        align = 1'b0;
        check("align locked drop", locked, 0);
        for (int j = 1; j <= 15; j++) begin
            step();
            check("align tick0",   tick[0],   ((j - 1) % 5 == 0));
            check("align tick1",   tick[1],   ((j + 1) % 5 == 0));
            check("align outclk1", outclk[1], ((j + 1) % 5 < 4));
            check("align relock",  locked,    (j == 15));
        end
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
